// File: rtl/seq_mul24_shift_add_if.sv
// Handshake and adder-loop signals between the control unit, the multiplier and the shared adder.
interface seq_mul24_shift_add_if #(
    parameter int WIDTH = 24
);
    logic                 Start;
    logic [WIDTH-1:0]     MulA;
    logic [WIDTH-1:0]     MulB;
    logic [WIDTH-1:0]     AddA;
    logic [WIDTH-1:0]     AddB;
    logic                 AddCin;
    logic [WIDTH-1:0]     AddSum;
    logic                 AddCout;
    logic                 Busy;
    logic                 Done;
    logic [2*WIDTH-1:0]   Product;

    modport master (
        output Start, MulA, MulB, AddSum, AddCout,
        input  AddA, AddB, AddCin, Busy, Done, Product
    );

    modport slave (
        input  Start, MulA, MulB, AddSum, AddCout,
        output AddA, AddB, AddCin, Busy, Done, Product
    );
endinterface

// File: rtl/seq_mul24_shift_add.sv
// Sequential unsigned shift-and-add multiplier; one partial product per clock through the external adder.
module seq_mul24_shift_add #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    seq_mul24_shift_add_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     phi_q, phi_d;
    logic [WIDTH-1:0]     plo_q, plo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     add_b;
    logic [2*WIDTH-1:0]   shifted;

    // Carry-out lands in the PHi MSB; the shift drops the consumed multiplier bit.
    assign shifted = {bus.AddCout, bus.AddSum, plo_q[WIDTH-1:1]};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            phi_q     <= '0;
            plo_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            phi_q     <= phi_d;
            plo_q     <= plo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        phi_d     = phi_q;
        plo_d     = plo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        add_b     = '0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    m_d     = bus.MulA;
                    plo_d   = bus.MulB;
                    phi_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_b          = plo_q[0] ? m_q : '0;
                {phi_d, plo_d} = shifted;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = shifted;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.AddA    = phi_q;
    assign bus.AddB    = add_b;
    assign bus.AddCin  = 1'b0;
    assign bus.Busy    = (state_q == RUN);
    assign bus.Done    = (state_q == DONE);
    assign bus.Product = product_q;
endmodule
